memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//   Shares the single-port data memory between instruction fetch (IF) and the
//   data-memory stage (DM). Arbitrates round-robin and sequences each access
//   with an issue, wait and acknowledge FSM. Emits a one-cycle count_access
//   pulse per issued access, which drives the memory access counter.
// PARAMETERS
//   ADDR_W       16  address width
//   DATA_W       16  data width
//   MEM_LATENCY   1  cycles from mem_en to valid mem_rdata; legal range 1..15
// PORTS
//   clk          in   1       system clock; all logic on posedge
//   reset        in   1       synchronous, active-high reset
//   if_req       in   1       IF read request; held until if_ack
//   if_addr      in   ADDR_W  IF read address
//   if_ack       out  1       one-cycle pulse; if_rdata valid this cycle
//   if_rdata     out  DATA_W  IF read data (registered)
//   dm_req       in   1       DM request; held until dm_ack
//   dm_we        in   1       1 = write, 0 = read
//   dm_addr      in   ADDR_W  DM address
//   dm_wdata     in   DATA_W  DM write data
//   dm_ack       out  1       one-cycle pulse; dm_rdata valid on reads
//   dm_rdata     out  DATA_W  DM read data (registered)
//   mem_en       out  1       memory strobe, one cycle per access
//   mem_we       out  1       memory write enable; qualified by mem_en
//   mem_addr     out  ADDR_W  latched access address
//   mem_wdata    out  DATA_W  latched write data
//   mem_rdata    in   DATA_W  memory read data
//   count_access out  1       pulse coincident with mem_en (reads and writes)
//   busy         out  1       1 whenever the FSM is not in IDLE
// BEHAVIOUR
//   Reset (sync): state=IDLE; every output=0; if_rdata=dm_rdata=0; last_grant=DM.
//     The IF requester therefore wins the first tie.
//   States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   - IDLE: if any req is high, pick the winner and latch addr, we and wdata.
//       we is forced to 0 for IF. Record the winner as owner; go to ISSUE.
//       No req: stay in IDLE.
//   - Arbitration: a lone requester always wins. On a tie, the requester
//       opposite last_grant wins. last_grant updates on every grant.
//   - ISSUE: mem_en=count_access=1 for exactly 1 cycle. mem_we=latched we.
//       Load wait counter with MEM_LATENCY; go to WAIT.
//   - WAIT: decrement the counter each cycle. In the cycle it reaches 0
//       (ISSUE + MEM_LATENCY), capture mem_rdata into the owner's rdata
//       register, reads only. Writes leave rdata unchanged. Go to DONE.
//   - DONE: pulse the owner's ack for 1 cycle; the other ack stays 0. Go to IDLE.
//   - mem_addr and mem_wdata hold their latched value from ISSUE through DONE.
//       Their value is don't-care outside that window; mem_en and mem_we are
//       0 outside ISSUE.
//   Latency: req first seen in IDLE at cycle 0 -> mem_en at cycle 1
//     -> ack at cycle MEM_LATENCY+2. Throughput is 1 access per
//     MEM_LATENCY+3 cycles.
//   Handshake: the requester drops or changes req on the edge that samples ack.
//     A req still high in the cycle after ack counts as a new request.
//     The non-owner's req is held pending, never dropped.
//   Starvation: with both reqs continuously high, grants strictly alternate.
//   Reset mid-operation (ISSUE, WAIT or DONE): back to IDLE next edge with
//     every output 0. The in-flight access gets no ack and late mem_rdata is
//     ignored. The FSM does not begin a new access while reset is high.
//   busy is a decode of state != IDLE and has no extra latency.
// TESTING
//   T1 Reset 2 cycles, all inputs 0 -> every output 0, busy=0, no mem_en for
//      10 cycles.
//   T2 LAT=1, IF read of 0x0010, memory returns 0xBEEF -> cycle 1:
//      mem_en=count_access=1, mem_addr=0x0010, mem_we=0. Cycle 3: if_ack=1,
//      if_rdata=0xBEEF.
//   T3 DM write of 0x0020 with data 0x1234 -> in the mem_en cycle: mem_we=1,
//      mem_wdata=0x1234. Then one dm_ack pulse, dm_rdata unchanged, if_ack=0.
//   T4 if_req and dm_req both held high for 4 grants -> order IF, DM, IF, DM.
//      Exactly 4 count_access pulses, 4 cycles apart.
//   T5 Reset raised in the WAIT cycle of an IF read -> no if_ack, busy=0
//      after the edge. After reset is released, a DM read of 0x0030 completes
//      normally.
//   T6 MEM_LATENCY=3, IF read of 0x0040 returning 0x5A5A (valid at ISSUE+3)
//      -> mem_en at cycle 1, if_ack at cycle 5 with if_rdata=0x5A5A.

Source files
------------

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and the data-memory stage; each access runs IDLE -> ISSUE -> WAIT -> DONE.
module memory_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              count_access,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              ownerDm_q, ownerDm_d;
    logic              lastGrantDm_q, lastGrantDm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0] dmRdata_q, dmRdata_d;
    logic              grantDm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ownerDm_q     <= 1'b0;
            lastGrantDm_q <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            waitCnt_q     <= '0;
            ifRdata_q     <= '0;
            dmRdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            ownerDm_q     <= ownerDm_d;
            lastGrantDm_q <= lastGrantDm_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            waitCnt_q     <= waitCnt_d;
            ifRdata_q     <= ifRdata_d;
            dmRdata_q     <= dmRdata_d;
        end
    end

    // On a tie the requester opposite the previous grant wins, so neither starves.
    always_comb begin
        state_d       = state_q;
        ownerDm_d     = ownerDm_q;
        lastGrantDm_d = lastGrantDm_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        waitCnt_d     = waitCnt_q;
        ifRdata_d     = ifRdata_q;
        dmRdata_d     = dmRdata_q;
        grantDm       = dm_req && (!if_req || !lastGrantDm_q);

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    ownerDm_d     = grantDm;
                    lastGrantDm_d = grantDm;
                    addr_d        = grantDm ? dm_addr : if_addr;
                    we_d          = grantDm && dm_we;
                    wdata_d       = dm_wdata;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                waitCnt_d = 4'(MEM_LATENCY);
                state_d   = WAIT;
            end
            WAIT: begin
                waitCnt_d = waitCnt_q - 4'd1;
                if (waitCnt_q == 4'd1) begin
                    if (!we_q) begin
                        if (ownerDm_q) begin
                            dmRdata_d = mem_rdata;
                        end else begin
                            ifRdata_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_en       = (state_q == ISSUE);
    assign count_access = mem_en;
    assign mem_we       = mem_en && we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign if_ack       = (state_q == DONE) && !ownerDm_q;
    assign dm_ack       = (state_q == DONE) && ownerDm_q;
    assign if_rdata     = ifRdata_q;
    assign dm_rdata     = dmRdata_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: one instance at latency 1, one at
// latency 3, each with a small memory model returning data after the latency.
module tb_memory_arbiter;

    typedef struct {
        bit          isDm;
        logic [15:0] data;
    } sbEntry_t;

    logic        clk;
    logic        reset;
    int          checks;
    int          failures;
    sbEntry_t    sbQ[$];

    logic        ifReq, ifAck, dmReq, dmWe, dmAck;
    logic [15:0] ifAddr, ifRdata, dmAddr, dmWdata, dmRdata;
    logic        memEn, memWe, countAccess, busy;
    logic [15:0] memAddr, memWdata, memRdata;

    logic        ifReq3, ifAck3, dmReq3, dmWe3, dmAck3;
    logic [15:0] ifAddr3, ifRdata3, dmAddr3, dmWdata3, dmRdata3;
    logic        memEn3, memWe3, countAccess3, busy3;
    logic [15:0] memAddr3, memWdata3, memRdata3;

    logic [15:0] rdPipe1;
    logic        rdValid1;
    logic [15:0] rdPipe3a, rdPipe3b, rdPipe3c;
    logic [2:0]  rdValid3;
    logic [15:0] lastWrAddr, lastWrData;

    memory_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAck), .if_rdata(ifRdata),
        .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
        .dm_ack(dmAck), .dm_rdata(dmRdata),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .count_access(countAccess), .busy(busy)
    );

    memory_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3)) u3 (
        .clk(clk), .reset(reset),
        .if_req(ifReq3), .if_addr(ifAddr3), .if_ack(ifAck3), .if_rdata(ifRdata3),
        .dm_req(dmReq3), .dm_we(dmWe3), .dm_addr(dmAddr3), .dm_wdata(dmWdata3),
        .dm_ack(dmAck3), .dm_rdata(dmRdata3),
        .mem_en(memEn3), .mem_we(memWe3), .mem_addr(memAddr3), .mem_wdata(memWdata3),
        .mem_rdata(memRdata3), .count_access(countAccess3), .busy(busy3)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rdFunc(input logic [15:0] a);
        case (a)
            16'h0010: rdFunc = 16'hBEEF;
            16'h0030: rdFunc = 16'hC0DE;
            16'h0040: rdFunc = 16'h5A5A;
            default:  rdFunc = a ^ 16'hA5A5;
        endcase
    endfunction

    // Read data is only valid exactly MEM_LATENCY cycles after the strobe; otherwise garbage.
    always @(posedge clk) begin
        rdValid1 <= memEn && !memWe;
        rdPipe1  <= rdFunc(memAddr);
        if (memEn && memWe) begin
            lastWrAddr <= memAddr;
            lastWrData <= memWdata;
        end
        rdValid3 <= {rdValid3[1:0], memEn3 && !memWe3};
        rdPipe3a <= rdFunc(memAddr3);
        rdPipe3b <= rdPipe3a;
        rdPipe3c <= rdPipe3b;
    end

    assign memRdata  = rdValid1 ? rdPipe1 : 16'hDEAD;
    assign memRdata3 = rdValid3[2] ? rdPipe3c : 16'hDEAD;

    task automatic test_reset();
        int enCount;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifAck, dmAck, memEn, memWe, countAccess, busy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {ifAck, dmAck, memEn, memWe, countAccess, busy});
        end
        checks++;
        if ({ifRdata, dmRdata, memAddr, memWdata} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0",
                     {ifRdata, dmRdata, memAddr, memWdata});
        end
        checks++;
        if (busy3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy3: got %b expected 0", busy3);
        end
        reset   = 1'b0;
        enCount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (memEn === 1'b1) enCount++;
        end
        checks++;
        if (enCount !== 0) begin
            failures++;
            $display("[TB] FAIL idle_no_mem_en: got %0d expected 0", enCount);
        end
    endtask

    task automatic test_if_read();
        sbEntry_t exp;
        exp.isDm = 1'b0;
        exp.data = rdFunc(16'h0010);
        sbQ.push_back(exp);
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({memEn, countAccess, memWe} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL if_issue_strobes: got %b expected 110", {memEn, countAccess, memWe});
        end
        checks++;
        if (memAddr !== 16'h0010) begin
            failures++;
            $display("[TB] FAIL if_issue_addr: got %h expected 0010", memAddr);
        end
        @(negedge clk);
        checks++;
        if (ifAck !== 1'b0 || memEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL if_wait_cycle: got ack=%b en=%b expected 0 0", ifAck, memEn);
        end
        @(negedge clk);
        checks++;
        if ({ifAck, dmAck} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL if_ack_cycle3: got %b expected 10", {ifAck, dmAck});
        end
        exp = sbQ.pop_front();
        checks++;
        if (ifRdata !== exp.data) begin
            failures++;
            $display("[TB] FAIL if_rdata: got %h expected %h", ifRdata, exp.data);
        end
        ifReq = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ifAck !== 1'b0) begin
            failures++;
            $display("[TB] FAIL if_after_ack: got busy=%b ack=%b expected 0 0", busy, ifAck);
        end
    endtask

    task automatic test_dm_write();
        int ackCyc;
        int ifAcks;
        ackCyc = -1;
        ifAcks = 0;
        @(negedge clk);
        dmReq   = 1'b1;
        dmWe    = 1'b1;
        dmAddr  = 16'h0020;
        dmWdata = 16'h1234;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({memEn, memWe} !== 2'b11 || memWdata !== 16'h1234 || memAddr !== 16'h0020) begin
                    failures++;
                    $display("[TB] FAIL dm_write_issue: got en=%b we=%b addr=%h wdata=%h expected 1 1 0020 1234",
                             memEn, memWe, memAddr, memWdata);
                end
            end
            if (ifAck === 1'b1) ifAcks++;
            if (dmAck === 1'b1 && ackCyc < 0) begin
                ackCyc = c;
                dmReq  = 1'b0;
                dmWe   = 1'b0;
            end
        end
        checks++;
        if (ackCyc !== 3) begin
            failures++;
            $display("[TB] FAIL dm_write_ack_cycle: got %0d expected 3", ackCyc);
        end
        checks++;
        if (dmRdata !== 16'h0000 || ifAcks !== 0) begin
            failures++;
            $display("[TB] FAIL dm_write_side_effects: got rdata=%h ifAcks=%0d expected 0000 0", dmRdata, ifAcks);
        end
        checks++;
        if (lastWrAddr !== 16'h0020 || lastWrData !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL dm_write_memory: got %h/%h expected 0020/1234", lastWrAddr, lastWrData);
        end
    endtask

    task automatic test_back_to_back();
        sbEntry_t    exp;
        int          pulses;
        int          acks;
        int          lastPulse;
        int          gapBad;
        logic [15:0] got;
        pulses    = 0;
        acks      = 0;
        lastPulse = -1;
        gapBad    = 0;
        for (int g = 0; g < 4; g++) begin
            exp.isDm = (g % 2) == 1;
            exp.data = exp.isDm ? rdFunc(16'h0030) : rdFunc(16'h0010);
            sbQ.push_back(exp);
        end
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = 16'h0010;
        dmReq  = 1'b1;
        dmWe   = 1'b0;
        dmAddr = 16'h0030;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (countAccess === 1'b1) begin
                if (lastPulse >= 0 && c - lastPulse != 4) gapBad++;
                lastPulse = c;
                pulses++;
            end
            if (ifAck === 1'b1 || dmAck === 1'b1) begin
                checks++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL b2b_extra_ack: got ack %b expected none", {dmAck, ifAck});
                end else begin
                    exp = sbQ.pop_front();
                    if ({dmAck, ifAck} !== (exp.isDm ? 2'b10 : 2'b01)) begin
                        failures++;
                        $display("[TB] FAIL b2b_grant_order: got %b expected %b",
                                 {dmAck, ifAck}, exp.isDm ? 2'b10 : 2'b01);
                    end
                    checks++;
                    got = exp.isDm ? dmRdata : ifRdata;
                    if (got !== exp.data) begin
                        failures++;
                        $display("[TB] FAIL b2b_rdata: got %h expected %h", got, exp.data);
                    end
                end
                acks++;
                if (acks == 4) begin
                    ifReq = 1'b0;
                    dmReq = 1'b0;
                end
            end
        end
        checks++;
        if (pulses !== 4 || gapBad !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_pulses: got %0d pulses %0d bad gaps expected 4 0", pulses, gapBad);
        end
        checks++;
        if (acks !== 4 || sbQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_acks: got %0d acks %0d pending expected 4 0", acks, sbQ.size());
        end
    endtask

    task automatic test_reset_mid();
        sbEntry_t exp;
        int       ifAcks;
        int       ackCyc;
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, ifAck, memEn} !== 3'b000 || memAddr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: got busy=%b ack=%b en=%b addr=%h expected 0 0 0 0000",
                     busy, ifAck, memEn, memAddr);
        end
        checks++;
        if (ifRdata !== 16'h0000 || dmRdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL mid_reset_rdata: got %h/%h expected 0000/0000", ifRdata, dmRdata);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_blocks_start: got busy=%b expected 0", busy);
        end
        reset  = 1'b0;
        ifReq  = 1'b0;
        ifAcks = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ifAck === 1'b1) ifAcks++;
        end
        checks++;
        if (ifAcks !== 0) begin
            failures++;
            $display("[TB] FAIL mid_reset_no_ack: got %0d expected 0", ifAcks);
        end
        exp.isDm = 1'b1;
        exp.data = rdFunc(16'h0030);
        sbQ.push_back(exp);
        ackCyc = -1;
        dmReq  = 1'b1;
        dmWe   = 1'b0;
        dmAddr = 16'h0030;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (dmAck === 1'b1 && ackCyc < 0) begin
                ackCyc = c;
                dmReq  = 1'b0;
                exp    = sbQ.pop_front();
                checks++;
                if (dmRdata !== exp.data || ifRdata !== 16'h0000) begin
                    failures++;
                    $display("[TB] FAIL post_reset_dm_read: got dm=%h if=%h expected %h 0000",
                             dmRdata, ifRdata, exp.data);
                end
            end
        end
        checks++;
        if (ackCyc !== 3) begin
            failures++;
            $display("[TB] FAIL post_reset_ack_cycle: got %0d expected 3", ackCyc);
        end
    endtask

    task automatic test_latency3();
        sbEntry_t exp;
        int       enCyc;
        int       ackCyc;
        exp.isDm = 1'b0;
        exp.data = rdFunc(16'h0040);
        sbQ.push_back(exp);
        enCyc  = -1;
        ackCyc = -1;
        @(negedge clk);
        ifReq3  = 1'b1;
        ifAddr3 = 16'h0040;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (memEn3 === 1'b1 && enCyc < 0) enCyc = c;
            if (ifAck3 === 1'b1 && ackCyc < 0) begin
                ackCyc = c;
                ifReq3 = 1'b0;
                exp    = sbQ.pop_front();
                checks++;
                if (ifRdata3 !== exp.data) begin
                    failures++;
                    $display("[TB] FAIL lat3_rdata: got %h expected %h", ifRdata3, exp.data);
                end
            end
        end
        checks++;
        if (enCyc !== 1 || ackCyc !== 5) begin
            failures++;
            $display("[TB] FAIL lat3_timing: got en@%0d ack@%0d expected en@1 ack@5", enCyc, ackCyc);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        checks   = 0;
        failures = 0;
        ifReq    = 1'b0;  ifAddr  = '0;
        dmReq    = 1'b0;  dmWe    = 1'b0;  dmAddr  = '0;  dmWdata  = '0;
        ifReq3   = 1'b0;  ifAddr3 = '0;
        dmReq3   = 1'b0;  dmWe3   = 1'b0;  dmAddr3 = '0;  dmWdata3 = '0;
        test_reset();
        test_if_read();
        test_dm_write();
        test_back_to_back();
        test_reset_mid();
        test_latency3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
